cpu_mem_responder: RTL

- Memory-side responder for the multi-cycle RV32I core's two memory ports: an instruction fetch port (read-only) and a data port (read plus byte-strobed write).
- Holds one shared word array and returns registered read data with fixed latency.
- Right-aligns load data to the byte offset, so the core's lb/lh/lbu/lhu extraction from data_out[7:0]/[15:0] is correct.
- Flags out-of-range accesses.

---
 rtl/cpu_mem_responder_pkg.sv | 25 ++
 rtl/dp_byte_ram.sv | 41 ++++
 rtl/cpu_mem_responder.sv | 121 ++++++++++++
 3 files changed

// File: rtl/cpu_mem_responder_pkg.sv
// Shared types and limits for the RV32I memory responder.
// Imported by the responder top and its byte-lane RAM.
package cpu_mem_responder_pkg;

   localparam int LANES            = 4;
   localparam int READ_LATENCY_MAX = 3;

   typedef logic [LANES-1:0] strobe_t;
   typedef logic [1:0]       offset_t;

   typedef struct packed {
      logic    valid;
      offset_t off;
      logic    oob;
   } meta_t;

   function automatic logic [31:0] align(
      input logic [31:0] w,
      input offset_t     off,
      input logic        oob
   );
      return oob ? 32'h0 : (w >> {off, 3'b000});
   endfunction

endpackage

// File: rtl/dp_byte_ram.sv
// Word array with two registered read ports and one byte-strobed
// write port; reads see the word as it was before a same-edge write.
module dp_byte_ram
   import cpu_mem_responder_pkg::*;
#(
   parameter int ADDR_WIDTH = 14
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  a_en,
   input  logic [ADDR_WIDTH-1:0] a_addr,
   output logic [31:0]           a_q,
   input  logic                  b_en,
   input  logic [ADDR_WIDTH-1:0] b_addr,
   output logic [31:0]           b_q,
   input  strobe_t               we,
   input  logic [ADDR_WIDTH-1:0] w_addr,
   input  logic [31:0]           w_data
);

   logic [31:0] mem [2**ADDR_WIDTH];

   // byte-lane writes; contents survive reset
   always_ff @(posedge clk) begin
      for (int i = 0; i < LANES; i++) begin
         if (we[i]) mem[w_addr][8*i +: 8] <= w_data[8*i +: 8];
      end
   end

   // read registers hold their word until the next enabled read
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q <= '0;
         b_q <= '0;
      end else begin
         if (a_en) a_q <= mem[a_addr];
         if (b_en) b_q <= mem[b_addr];
      end
   end

endmodule

// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the multi-cycle core: fetch and data
// ports, load alignment, range checks, latency and access counters.
module cpu_mem_responder
   import cpu_mem_responder_pkg::*;
#(
   parameter int ADDR_WIDTH   = 14,
   parameter int READ_LATENCY = 1,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 instr_read,
   input  logic [31:0]          instr_addr,
   output logic [31:0]          instr_out,
   input  logic                 data_read,
   input  logic [3:0]           data_write,
   input  logic [31:0]          data_addr,
   input  logic [31:0]          data_in,
   output logic [31:0]          data_out,
   output logic                 addr_err,
   output logic [CNT_WIDTH-1:0] rd_count,
   output logic [CNT_WIDTH-1:0] wr_count
);

   localparam int L  = READ_LATENCY;
   localparam int HI = ADDR_WIDTH + 2;

   logic        i_oob;
   logic        d_oob;
   logic        err_hit;
   meta_t       rq    [2];
   logic [31:0] ram_q [2];
   logic [31:0] res   [2];

   assign i_oob = |instr_addr[31:HI];
   assign d_oob = |data_addr[31:HI];

   assign rq[0] = '{valid: instr_read, off: 2'b00, oob: i_oob};
   assign rq[1] = '{valid: data_read, off: data_addr[1:0], oob: d_oob};

   dp_byte_ram #(
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_ram (
      .clk    (clk),
      .rst_n  (rst_n),
      .a_en   (instr_read),
      .a_addr (instr_addr[HI-1:2]),
      .a_q    (ram_q[0]),
      .b_en   (data_read),
      .b_addr (data_addr[HI-1:2]),
      .b_q    (ram_q[1]),
      .we     (data_write & {LANES{~d_oob}}),
      .w_addr (data_addr[HI-1:2]),
      .w_data (data_in)
   );

   for (genvar p = 0; p < 2; p++) begin : g_port
      meta_t       m [L];
      logic [31:0] fw;

      // request metadata rides alongside the array read; last stage holds
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int s = 0; s < L; s++) m[s] <= '0;
         end else begin
            if (L > 1 || rq[p].valid) m[0] <= rq[p];
            for (int s = 1; s < L; s++) begin
               if (s < L - 1 || m[s-1].valid) m[s] <= m[s-1];
            end
         end
      end

      if (L == 1) begin : g_direct
         assign fw = ram_q[p];
      end else begin : g_delay
         logic [31:0] wq [1:L-1];

         // word follows its metadata; last stage holds between reads
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int s = 1; s < L; s++) wq[s] <= '0;
            end else begin
               if (L > 2 || m[0].valid) wq[1] <= ram_q[p];
               for (int s = 2; s < L; s++) begin
                  if (s < L - 1 || m[s-1].valid) wq[s] <= wq[s-1];
               end
            end
         end

         assign fw = wq[L-1];
      end

      assign res[p] = align(fw, m[L-1].off, m[L-1].oob);
   end

   assign instr_out = res[0];
   assign data_out  = res[1];

   assign err_hit = (instr_read && (i_oob || instr_addr[1:0] != 2'b00))
                 || ((data_read || |data_write) && d_oob);

   // sticky range / misaligned-fetch flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       addr_err <= 1'b0;
      else if (err_hit) addr_err <= 1'b1;
   end

   // saturating data-port access counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_count <= '0;
         wr_count <= '0;
      end else begin
         if (data_read && !(&rd_count))
            rd_count <= rd_count + CNT_WIDTH'(1);
         if (|data_write && !(&wr_count))
            wr_count <= wr_count + CNT_WIDTH'(1);
      end
   end

endmodule
